eco32f_lsu: RTL

- Memory-stage load/store unit of the eco32f pipeline. It sits directly downstream of the execute-stage ALU.
- On the EX→MEM edge it captures the ALU add result as the effective address, plus the store data and access width.
- It runs one big-endian data-bus transaction per access and stalls MEM until the bus terminates.
- It delivers sign- or zero-extended load data to the writeback stage.

---
 rtl/eco32f_lsu_pkg.sv | 26 ++
 rtl/eco32f_lsu_lane.sv | 83 ++++++++
 rtl/eco32f_lsu.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/eco32f_lsu_pkg.sv
// Shared eco32f LSU definitions: access-width encodings, FSM states, MEM request record.
package eco32f_lsu_pkg;

    localparam logic [1:0] LSU_BYTE = 2'd0;
    localparam logic [1:0] LSU_HALF = 2'd1;
    localparam logic [1:0] LSU_WORD = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } lsu_state_t;

    // What the MEM stage must remember to finish a load once the bus terminates.
    typedef struct packed {
        logic       load;
        logic       zext;
        logic [1:0] width;
        logic [1:0] adr_lo;
    } mem_req_t;

    // The reserved encoding 3 behaves as a word access.
    function automatic logic [1:0] lsu_norm_width(input logic [1:0] w);
        return (w == LSU_BYTE || w == LSU_HALF) ? w : LSU_WORD;
    endfunction

endpackage

// File: rtl/eco32f_lsu_lane.sv
// Big-endian lane steering: request-side sel/store replication/misalign, response-side extraction.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
module eco32f_lsu_lane
    import eco32f_lsu_pkg::*;
#(
    parameter int ALIGN_CHECK = 1
) (
    input  logic [1:0]  req_width,
    input  logic [31:0] req_adr,
    input  logic [31:0] req_dat,
    output logic [31:0] req_adr_eff,
    output logic [3:0]  req_sel,
    output logic [31:0] req_dat_rep,
    output logic        req_misalign,
    input  logic [1:0]  rsp_width,
    input  logic [1:0]  rsp_adr_lo,
    input  logic        rsp_zext,
    input  logic [31:0] rsp_dat,
    output logic [31:0] rsp_result
);

    logic [1:0]  w_req;
    logic [1:0]  w_rsp;
    logic        misalign_raw;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign w_req = lsu_norm_width(req_width);
    assign w_rsp = lsu_norm_width(rsp_width);

    // Without alignment checking the offending low bits are simply dropped.
    always_comb begin
        req_adr_eff = req_adr;
        case (w_req)
            LSU_HALF: misalign_raw = req_adr[0];
            LSU_WORD: misalign_raw = |req_adr[1:0];
            default:  misalign_raw = 1'b0;
        endcase
        if (ALIGN_CHECK == 0) begin
            if (w_req == LSU_HALF) begin
                req_adr_eff[0] = 1'b0;
            end else if (w_req == LSU_WORD) begin
                req_adr_eff[1:0] = 2'b00;
            end
        end
    end

    assign req_misalign = (ALIGN_CHECK != 0) && misalign_raw;

    always_comb begin
        case (w_req)
            LSU_BYTE: begin
                req_sel     = 4'b1000 >> req_adr_eff[1:0];
                req_dat_rep = {4{req_dat[7:0]}};
            end
            LSU_HALF: begin
                req_sel     = req_adr_eff[1] ? 4'b0011 : 4'b1100;
                req_dat_rep = {2{req_dat[15:0]}};
            end
            default: begin
                req_sel     = 4'b1111;
                req_dat_rep = req_dat;
            end
        endcase
    end

    always_comb begin
        case (rsp_adr_lo)
            2'd0:    byte_v = rsp_dat[31:24];
            2'd1:    byte_v = rsp_dat[23:16];
            2'd2:    byte_v = rsp_dat[15:8];
            default: byte_v = rsp_dat[7:0];
        endcase
        half_v = rsp_adr_lo[1] ? rsp_dat[15:0] : rsp_dat[31:16];
        case (w_rsp)
            LSU_BYTE: rsp_result = {{24{byte_v[7] & ~rsp_zext}}, byte_v};
            LSU_HALF: rsp_result = {{16{half_v[15] & ~rsp_zext}}, half_v};
            default:  rsp_result = rsp_dat;
        endcase
    end

endmodule

// File: rtl/eco32f_lsu.sv
// eco32f memory-stage load/store unit: one big-endian data-bus cycle per access.
// Latency: bus signals one cycle after EX->MEM accept; load result registered on the terminating edge.
// Backpressure: mem_lsu_stall holds MEM while the bus cycle is open; ex_stall blocks new requests.
module eco32f_lsu
    import eco32f_lsu_pkg::*;
#(
    parameter int ALIGN_CHECK = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_stall,
    input  logic        ex_op_load,
    input  logic        ex_op_store,
    input  logic [1:0]  ex_lsu_width,
    input  logic        ex_lsu_zext,
    input  logic [31:0] ex_add_result,
    input  logic [31:0] ex_rf_y,
    output logic        mem_lsu_stall,
    output logic        mem_except_align,
    output logic        wb_except_bus,
    output logic        wb_op_load,
    output logic [31:0] wb_lsu_result,
    output logic [31:0] dbus_adr_o,
    output logic [31:0] dbus_dat_o,
    output logic [3:0]  dbus_sel_o,
    output logic        dbus_we_o,
    output logic        dbus_cyc_o,
    output logic        dbus_stb_o,
    input  logic [31:0] dbus_dat_i,
    input  logic        dbus_ack_i,
    input  logic        dbus_err_i
);

    lsu_state_t  state, state_nxt;
    mem_req_t    mem_req;
    logic        term;
    logic        req;
    logic        accept;
    logic        accept_bus;
    logic [31:0] lane_adr_eff;
    logic [3:0]  lane_sel;
    logic [31:0] lane_dat;
    logic        lane_misalign;
    logic [31:0] lane_result;

    eco32f_lsu_lane #(
        .ALIGN_CHECK(ALIGN_CHECK)
    ) u_lane (
        .req_width   (ex_lsu_width),
        .req_adr     (ex_add_result),
        .req_dat     (ex_rf_y),
        .req_adr_eff (lane_adr_eff),
        .req_sel     (lane_sel),
        .req_dat_rep (lane_dat),
        .req_misalign(lane_misalign),
        .rsp_width   (mem_req.width),
        .rsp_adr_lo  (mem_req.adr_lo),
        .rsp_zext    (mem_req.zext),
        .rsp_dat     (dbus_dat_i),
        .rsp_result  (lane_result)
    );

    // A new request may only enter when MEM is free or is being freed on this edge.
    assign term       = (state == ST_BUS) && (dbus_ack_i || dbus_err_i);
    assign req        = !ex_stall && (ex_op_load || ex_op_store);
    assign accept     = req && ((state == ST_IDLE) || term);
    assign accept_bus = accept && !lane_misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept_bus) state_nxt = ST_BUS;
            ST_BUS:  if (term)       state_nxt = accept_bus ? ST_BUS : ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_lsu_stall = (state == ST_BUS) && !(dbus_ack_i || dbus_err_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req          <= '0;
            mem_except_align <= 1'b0;
            wb_except_bus    <= 1'b0;
            wb_op_load       <= 1'b0;
            wb_lsu_result    <= 32'd0;
            dbus_adr_o       <= 32'd0;
            dbus_dat_o       <= 32'd0;
            dbus_sel_o       <= 4'd0;
            dbus_we_o        <= 1'b0;
            dbus_cyc_o       <= 1'b0;
            dbus_stb_o       <= 1'b0;
        end else begin
            wb_op_load       <= 1'b0;
            wb_except_bus    <= 1'b0;
            mem_except_align <= 1'b0;

            // err takes priority over a simultaneous ack and leaves the result untouched.
            if (term) begin
                if (dbus_err_i) begin
                    wb_except_bus <= 1'b1;
                end else begin
                    wb_op_load <= mem_req.load;
                    if (mem_req.load) begin
                        wb_lsu_result <= lane_result;
                    end
                end
            end

            if (accept) begin
                mem_req.load     <= ex_op_load && !ex_op_store;
                mem_req.zext     <= ex_lsu_zext;
                mem_req.width    <= ex_lsu_width;
                mem_req.adr_lo   <= lane_adr_eff[1:0];
                mem_except_align <= lane_misalign;
            end

            if (accept_bus) begin
                dbus_adr_o <= {lane_adr_eff[31:2], 2'b00};
                dbus_dat_o <= lane_dat;
                dbus_sel_o <= lane_sel;
                dbus_we_o  <= ex_op_store;
                dbus_cyc_o <= 1'b1;
                dbus_stb_o <= 1'b1;
            end else if (term) begin
                dbus_adr_o <= 32'd0;
                dbus_dat_o <= 32'd0;
                dbus_sel_o <= 4'd0;
                dbus_we_o  <= 1'b0;
                dbus_cyc_o <= 1'b0;
                dbus_stb_o <= 1'b0;
            end
        end
    end

endmodule
